// File: rtl/alu_src_if.sv
// Handshake and decoded operand-B bundle between the instruction source, alu_src_ctrl and its consumer.
// slave = the alu_src_ctrl side, master = the side driving instructions and consuming results.
interface alu_src_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic        alu_src;
    logic [63:0] imm_ext;
    logic        illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_src, imm_ext, illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_src, imm_ext, illegal
    );
endinterface

// File: rtl/alu_src_ctrl.sv
// One-entry registered decode stage producing the LEGv8 operand-B mux select and extended immediate.
// Optional MOVZ decode is enabled with `define ALU_SRC_MOVZ_EN.
module alu_src_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    alu_src_if.slave   bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_nxt;
    logic        accept, drain;
    logic        dec_alu_src, dec_illegal;
    logic [63:0] dec_imm;
    logic        alu_src_q, illegal_q;
    logic [63:0] imm_q;
    logic        unused_instr;

    // Rd/Rt field never affects operand-B selection.
    assign unused_instr = ^bus.instr[4:0];

    assign bus.in_ready  = (state == EMPTY) | bus.out_ready;
    assign bus.out_valid = (state == FULL);
    assign accept        = bus.in_valid & bus.in_ready;
    assign drain         = bus.out_valid & bus.out_ready;

    // Decode in priority order: widest opcode field wins.
    always_comb begin
        dec_alu_src = 1'b1;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        if (bus.instr[31:21] == 11'b10001011000 || bus.instr[31:21] == 11'b11001011000 ||
            bus.instr[31:21] == 11'b10001010000 || bus.instr[31:21] == 11'b10101010000) begin
            dec_alu_src = 1'b1;
        end else if (bus.instr[31:21] == 11'b11111000010 || bus.instr[31:21] == 11'b11111000000) begin
            dec_alu_src = 1'b0;
            dec_imm     = {{55{bus.instr[20]}}, bus.instr[20:12]};
        end else if (bus.instr[31:22] == 10'b1001000100 || bus.instr[31:22] == 10'b1101000100 ||
                     bus.instr[31:22] == 10'b1001001000 || bus.instr[31:22] == 10'b1011001000) begin
            dec_alu_src = 1'b0;
            dec_imm     = {52'b0, bus.instr[21:10]};
        end
`ifdef ALU_SRC_MOVZ_EN
        else if (bus.instr[31:23] == 9'b110100101) begin
            dec_alu_src = 1'b0;
            dec_imm     = {48'b0, bus.instr[20:5]} << {bus.instr[22:21], 4'b0000};
        end
`endif
        else if (bus.instr[31:24] == 8'b10110100) begin
            dec_alu_src = 1'b1;
            dec_imm     = {{45{bus.instr[23]}}, bus.instr[23:5]};
        end else if (bus.instr[31:26] == 6'b000101) begin
            dec_alu_src = 1'b0;
            dec_imm     = {{38{bus.instr[25]}}, bus.instr[25:0]};
        end else begin
            dec_illegal = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (drain && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Payload only moves on accept, so it holds while FULL and stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src_q <= 1'b1;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            alu_src_q <= dec_alu_src;
            imm_q     <= dec_imm;
            illegal_q <= dec_illegal;
        end
    end

    assign bus.alu_src = alu_src_q;
    assign bus.imm_ext = imm_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_src_ctrl.sv
// Scoreboard bench for alu_src_ctrl: expected decode pushed on accept, compared while held, popped on drain.
module tb_alu_src_ctrl;
    typedef struct {
        logic        a;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    localparam logic [31:0] W_ADDI = 32'h913FFC41;
    localparam logic [31:0] W_LDUR = 32'hF85F8000;
    localparam logic [31:0] W_ADD  = 32'h8B030041;
    localparam logic [31:0] W_ILL  = 32'hFFFFFFFF;
    localparam logic [31:0] W_MOVZ = 32'hD2C24680;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_src_if bus();
    alu_src_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sbq[$];
    logic m_full = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e.a = 1'b1; e.imm = 64'd0; e.ill = 1'b0;
        if (w[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550}) begin
            e.a = 1'b1;
        end else if (w[31:21] inside {11'h7C2, 11'h7C0}) begin
            e.a = 1'b0; e.imm = 64'($signed(w[20:12]));
        end else if (w[31:22] inside {10'h244, 10'h344, 10'h248, 10'h2C8}) begin
            e.a = 1'b0; e.imm = 64'(w[21:10]);
        end
`ifdef ALU_SRC_MOVZ_EN
        else if (w[31:23] == 9'h1A5) begin
            e.a = 1'b0; e.imm = 64'(w[20:5]) << (16 * w[22:21]);
        end
`endif
        else if (w[31:24] == 8'hB4) begin
            e.a = 1'b1; e.imm = 64'($signed(w[23:5]));
        end else if (w[31:26] == 6'h05) begin
            e.a = 1'b0; e.imm = 64'($signed(w[25:0]));
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] pick_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {11'h458 | (11'h200 & 11'($urandom)), r[20:0]};
            1: return {11'h7C2, r[20:0]};
            2: return {11'h7C0, r[20:0]};
            3: return {10'h344, r[21:0]};
            4: return {8'hB4, r[23:0]};
            5: return {6'h05, r[25:0]};
            6: return {9'h1A5, r[22:0]};
            default: return r;
        endcase
    endfunction

    task automatic drive(input logic iv, input logic [31:0] w, input logic ordy);
        @(negedge clk);
        bus.in_valid = iv; bus.instr = w; bus.out_ready = ordy;
        #1;
        if (m_full && ordy) sbq.delete(0);
        if (iv && (!m_full || ordy)) begin
            sbq.push_back(model(w)); m_full = 1'b1;
        end else if (ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_tests++;
        if ({bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b0, 1'b1, 64'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state: got %b/%b/%h/%b exp 0/1/0/0", bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
        drive(1'b1, W_LDUR, 1'b0);
        #2 rst_n = 1'b0; #1;
        sbq.delete(); m_full = 1'b0;
        n_tests++;
        if ({bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b0, 1'b1, 64'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_full: got %b/%b/%h/%b exp 0/1/0/0", bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal);
        end
        @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_addi();
        drive(1'b1, W_ADDI, 1'b1);
        n_tests++;
        if ({bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b1, 1'b0, 64'h0000000000000FFF, 1'b0}) begin
            n_fail++; $display("FAIL addi: got %b/%b/%h/%b exp 1/0/fff/0", bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal);
        end
        drive(1'b0, 32'd0, 1'b1);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got vld=%b exp 0", bus.out_valid); end
    endtask

    task automatic test_ldur_add();
        drive(1'b1, W_LDUR, 1'b1);
        n_tests++;
        if ({bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0}) begin
            n_fail++; $display("FAIL ldur: got %b/%h/%b exp 0/fffffffffffffff8/0", bus.alu_src, bus.imm_ext, bus.illegal);
        end
        drive(1'b1, W_ADD, 1'b1);
        n_tests++;
        if ({bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
            n_fail++; $display("FAIL add: got %b/%b/%h/%b exp 1/1/0/0", bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal);
        end
        drive(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        drive(1'b1, W_ADDI, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b0);
            n_tests++;
            if ({bus.in_ready, bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b0, 1'b1, 1'b0, 64'hFFF, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got rdy=%b vld=%b %b/%h/%b exp 0/1 0/fff/0", i, bus.in_ready, bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal);
            end
        end
        drive(1'b1, W_LDUR, 1'b1);
        n_tests++;
        if ({bus.out_valid, bus.alu_src, bus.imm_ext} !== {1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8}) begin
            n_fail++; $display("FAIL drain_accept: got vld=%b %b/%h exp 1 0/fffffffffffffff8", bus.out_valid, bus.alu_src, bus.imm_ext);
        end
        drive(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_illegal();
        drive(1'b1, W_ILL, 1'b1);
        n_tests++;
        if ({bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal} !== {1'b1, 1'b1, 64'd0, 1'b1}) begin
            n_fail++; $display("FAIL illegal: got %b/%b/%h/%b exp 1/1/0/1", bus.out_valid, bus.alu_src, bus.imm_ext, bus.illegal);
        end
        drive(1'b1, W_ADDI, 1'b1);
        n_tests++;
        if ({bus.illegal, bus.alu_src, bus.imm_ext} !== {1'b0, 1'b0, 64'hFFF}) begin
            n_fail++; $display("FAIL illegal_clear: got %b/%b/%h exp 0/0/fff", bus.illegal, bus.alu_src, bus.imm_ext);
        end
        drive(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_movz();
        exp_t e;
`ifdef ALU_SRC_MOVZ_EN
        e = '{a: 1'b0, imm: 64'h0000123400000000, ill: 1'b0};
`else
        e = '{a: 1'b1, imm: 64'd0, ill: 1'b1};
`endif
        drive(1'b1, W_MOVZ, 1'b1);
        n_tests++;
        if ({bus.alu_src, bus.imm_ext, bus.illegal} !== {e.a, e.imm, e.ill}) begin
            n_fail++; $display("FAIL movz: got %b/%h/%b exp %b/%h/%b", bus.alu_src, bus.imm_ext, bus.illegal, e.a, e.imm, e.ill);
        end
        drive(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic iv, ordy;
        for (int i = 0; i < 60; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            drive(iv, pick_word(), ordy);
            n_tests++;
            if (bus.in_ready !== (!m_full || ordy) || bus.out_valid !== m_full) begin
                n_fail++; $display("FAIL b2b_hs[%0d]: got rdy=%b vld=%b exp rdy=%b vld=%b", i, bus.in_ready, bus.out_valid, (!m_full || ordy), m_full);
            end else if (m_full) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++; $display("FAIL b2b_sb[%0d]: got empty queue exp one entry", i);
                end else if ({bus.alu_src, bus.imm_ext, bus.illegal} !== {sbq[0].a, sbq[0].imm, sbq[0].ill}) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %b/%h/%b exp %b/%h/%b", i, bus.alu_src, bus.imm_ext, bus.illegal, sbq[0].a, sbq[0].imm, sbq[0].ill);
                end
            end
        end
        drive(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.instr = 32'd0; bus.out_ready = 1'b0;
        test_reset();
        test_addi();
        test_ldur_add();
        test_backpressure();
        test_illegal();
        test_movz();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
